// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin, packet-locked two-input stream arbiter with a registered output
module mux2_rr_arbiter #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 64
) (
    input  logic             Clk_CI,
    input  logic             Rst_RI,
    input  logic [WIDTH-1:0] In0Data_DI,
    input  logic             In0Valid_SI,
    input  logic             In0Last_SI,
    output logic             In0Ready_SO,
    input  logic [WIDTH-1:0] In1Data_DI,
    input  logic             In1Valid_SI,
    input  logic             In1Last_SI,
    output logic             In1Ready_SO,
    output logic [WIDTH-1:0] OutData_DO,
    output logic             OutValid_SO,
    output logic             OutLast_SO,
    output logic             OutSrc_SO,
    input  logic             OutReady_SI,
    output logic             ErrLong_SO
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

    state_e           state_q;
    logic             prio_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_q, last_q, src_q, err_q;
    logic             free, sel, grant, acc, last;
    logic [WIDTH-1:0] data;

    assign OutData_DO  = data_q;
    assign OutValid_SO = valid_q;
    assign OutLast_SO  = last_q;
    assign OutSrc_SO   = src_q;
    assign ErrLong_SO  = err_q;

    // Pick the granted input (lock owner, else round-robin among valid requesters) and the mux path
    always_comb begin
        free        = !valid_q | OutReady_SI;
        sel         = (state_q == LOCK0) ? 1'b0 :
                      (state_q == LOCK1) ? 1'b1 :
                      (In0Valid_SI & In1Valid_SI) ? prio_q : In1Valid_SI;
        grant       = !Rst_RI & free & ((state_q != IDLE) | In0Valid_SI | In1Valid_SI);
        In0Ready_SO = grant & !sel;
        In1Ready_SO = grant & sel;
        acc         = sel ? (In1Valid_SI & In1Ready_SO) : (In0Valid_SI & In0Ready_SO);
        data        = sel ? In1Data_DI : In0Data_DI;
        last        = sel ? In1Last_SI : In0Last_SI;
        cnt_d       = (cnt_q == CW'(MAX_BURST)) ? cnt_q : cnt_q + 1'b1;
    end

    // Lock state, round-robin pointer, burst counter, error flag and output register
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            src_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (acc) begin
                data_q  <= data;
                last_q  <= last;
                src_q   <= sel;
                valid_q <= 1'b1;
            end else if (OutReady_SI) begin
                valid_q <= 1'b0;
            end
            if (acc && !last && cnt_q == CW'(MAX_BURST - 1))
                err_q <= 1'b1;
            if (acc) begin
                if (last) begin
                    state_q <= IDLE;
                    prio_q  <= !sel;
                    cnt_q   <= '0;
                end else begin
                    state_q <= sel ? LOCK1 : LOCK0;
                    cnt_q   <= cnt_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: directed and random checks of the arbiter against a rule-level model
module tb_mux2_rr_arbiter;
    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d0, d1, od;
    logic        v0, l0, r0, v1, l1, r1, ov, ol, os, ordy, err;

    int total = 0;
    int bad   = 0;

    // model of the observable state
    logic [15:0] m_data = '0;
    logic        m_vld = 1'b0, m_last = 1'b0, m_src = 1'b0, m_err = 1'b0;
    int          owner = -1;
    int          prio  = 0;
    int          beats = 0;

    mux2_rr_arbiter #(.WIDTH(16), .MAX_BURST(MAXB)) dut (
        .Clk_CI(clk), .Rst_RI(rst),
        .In0Data_DI(d0), .In0Valid_SI(v0), .In0Last_SI(l0), .In0Ready_SO(r0),
        .In1Data_DI(d1), .In1Valid_SI(v1), .In1Last_SI(l1), .In1Ready_SO(r1),
        .OutData_DO(od), .OutValid_SO(ov), .OutLast_SO(ol), .OutSrc_SO(os),
        .OutReady_SI(ordy), .ErrLong_SO(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int          g;
        logic        fr, acc, al;
        logic [15:0] ad;
        #3;
        fr = !m_vld || ordy;
        if (rst)                g = -1;
        else if (owner >= 0)    g = owner;
        else if (v0 && v1)      g = prio;
        else if (v0)            g = 0;
        else if (v1)            g = 1;
        else                    g = -1;
        chk("in0_ready", {31'b0, r0}, {31'b0, fr && g == 0});
        chk("in1_ready", {31'b0, r1}, {31'b0, fr && g == 1});
        chk("out_valid", {31'b0, ov}, {31'b0, m_vld});
        chk("out_data",  {16'b0, od}, {16'b0, m_data});
        chk("out_last",  {31'b0, ol}, {31'b0, m_last});
        chk("out_src",   {31'b0, os}, {31'b0, m_src});
        chk("err_long",  {31'b0, err}, {31'b0, m_err});
        acc = g >= 0 && fr && (g == 0 ? v0 : v1);
        ad  = g == 1 ? d1 : d0;
        al  = g == 1 ? l1 : l0;
        @(posedge clk);
        if (rst) begin
            m_data = '0; m_vld = 0; m_last = 0; m_src = 0; m_err = 0;
            owner = -1; prio = 0; beats = 0;
        end else if (acc) begin
            m_data = ad; m_last = al; m_src = (g == 1); m_vld = 1;
            beats++;
            if (!al && beats == MAXB) m_err = 1;
            if (al) begin
                owner = -1; prio = 1 - g; beats = 0;
            end else begin
                owner = g;
            end
        end else if (ordy) begin
            m_vld = 0;
        end
        #1;
    endtask

    task automatic step(input logic a0, input logic b0, input logic [15:0] x0,
                        input logic a1, input logic b1, input logic [15:0] x1,
                        input logic rdy, input logic r = 1'b0);
        v0 = a0; l0 = b0; d0 = x0;
        v1 = a1; l1 = b1; d1 = x1;
        ordy = rdy; rst = r;
        tick();
    endtask

    task automatic idle_reset();
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    initial begin
        rst = 1; v0 = 0; l0 = 0; d0 = 0; v1 = 0; l1 = 0; d1 = 0; ordy = 1;
        @(posedge clk);
        #1;
        // 1: three-beat packet on In0
        idle_reset();
        chk("rst_valid", {31'b0, ov}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        step(1, 0, 16'h0001, 0, 0, 0, 1);
        chk("t1_d1", {16'b0, od}, 32'h0001);
        step(1, 0, 16'h0002, 0, 0, 0, 1);
        step(1, 1, 16'h0003, 0, 0, 0, 1);
        chk("t1_d3", {16'b0, od}, 32'h0003);
        chk("t1_last", {31'b0, ol}, 32'd1);
        chk("t1_src", {31'b0, os}, 32'd0);
        step(1, 1, 16'h00AA, 1, 1, 16'h00BB, 1);
        chk("t1_prio", {16'b0, od}, 32'h00BB);
        // 2: alternating single-beat packets, no bubbles
        idle_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 16'hAAAA, 1, 1, 16'h5555, 1);
            chk("t2_alt", {16'b0, od}, (i % 2 == 0) ? 32'hAAAA : 32'h5555);
            chk("t2_vld", {31'b0, ov}, 32'd1);
        end
        // 3: In1 waits for In0's four-beat packet
        idle_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, i == 3, 16'(16'h0100 + i), 1, 1, 16'h0F0F, 1);
            chk("t3_hold", {31'b0, os}, 32'd0);
        end
        step(0, 0, 0, 1, 1, 16'h0F0F, 1);
        chk("t3_switch", {16'b0, od}, 32'h0F0F);
        chk("t3_src", {31'b0, os}, 32'd1);
        // 4: backpressure in the middle of a packet
        idle_reset();
        step(1, 0, 16'h0011, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 16'h0022, 1, 1, 16'h0099, 0);
            chk("t4_stable", {16'b0, od}, 32'h0011);
        end
        step(1, 0, 16'h0022, 0, 0, 0, 1);
        chk("t4_d2", {16'b0, od}, 32'h0022);
        step(1, 1, 16'h0033, 0, 0, 0, 1);
        chk("t4_d3", {16'b0, od}, 32'h0033);
        // 5: overlong packet raises the sticky error
        idle_reset();
        for (int i = 1; i <= 6; i++) begin
            step(1, i == 6, 16'(i), 0, 0, 0, 1);
            chk("t5_data", {16'b0, od}, i);
            chk("t5_err", {31'b0, err}, {31'b0, i >= 4});
        end
        step(0, 0, 0, 0, 0, 0, 1);
        chk("t5_sticky", {31'b0, err}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        chk("t5_clear", {31'b0, err}, 32'd0);
        // 6: reset mid-packet
        step(1, 0, 16'h0A01, 0, 0, 0, 1);
        step(1, 0, 16'h0A02, 0, 0, 0, 1, 1);
        chk("t6_valid", {31'b0, ov}, 32'd0);
        step(0, 0, 0, 1, 1, 16'h0B01, 1);
        chk("t6_grant", {16'b0, od}, 32'h0B01);
        chk("t6_src", {31'b0, os}, 32'd1);
        // random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0, 16'($urandom),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0, 16'($urandom),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
Two-input stream arbiter that shares one MUX2-style datapath between two requesters. It picks an input by round-robin, holds the grant for a whole packet (until Last), and drives the mux select internally. The selected beat is registered onto a single output stream. It sits in front of shared nyq processing blocks that accept one stream at a time.

Parameters:
WIDTH, 16, data width of each input and the output stream
MAX_BURST, 64, beats per packet before the long-packet error flag is raised (must be >= 2)

Ports:
Clk_CI  input  1  clock, rising edge
Rst_RI  input  1  reset, synchronous, active-high
In0Data_DI  input  WIDTH  requester 0 data
In0Valid_SI  input  1  requester 0 beat valid
In0Last_SI  input  1  requester 0 last beat of packet
In0Ready_SO  output  1  requester 0 beat accepted when In0Valid_SI&In0Ready_SO
In1Data_DI  input  WIDTH  requester 1 data
In1Valid_SI  input  1  requester 1 beat valid
In1Last_SI  input  1  requester 1 last beat of packet
In1Ready_SO  output  1  requester 1 beat accepted when In1Valid_SI&In1Ready_SO
OutData_DO  output  WIDTH  registered selected data
OutValid_SO  output  1  output beat valid
OutLast_SO  output  1  registered Last of the selected beat
OutSrc_SO  output  1  source index of the current output beat (0/1)
OutReady_SI  input  1  downstream ready
ErrLong_SO  output  1  sticky: a packet exceeded MAX_BURST beats

Behaviour:
- Clock and reset: one clock, Clk_CI. Rst_RI is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - OutValid_SO=0, OutData_DO=0, OutLast_SO=0, OutSrc_SO=0, ErrLong_SO=0.
  - State=IDLE, round-robin pointer Prio_S=0 (input 0 favoured), beat counter=0.
  - InxReady_SO=0 while Rst_RI=1.
- Slot free: Free = !OutValid_SO | OutReady_SI. This is the single-entry output register, so full throughput is possible.
- State machine: IDLE, LOCK0, LOCK1.
  - IDLE, Sel computation:
    - Only one input valid: Sel = that input.
    - Both valid: Sel = Prio_S.
    - Neither valid: no grant.
    - Sel is combinational. The first beat is accepted in the same cycle if Free.
  - IDLE, on acceptance:
    - Last=1: stay IDLE, Prio_S <= !Sel.
    - Last=0: go to LOCKSel, counter <= 1.
  - LOCKx:
    - Only input x is eligible. In(!x)Ready_SO=0.
    - InxReady_SO = Free.
    - Accepted beat with Last=1: go to IDLE, Prio_S <= !x, counter <= 0.
    - Accepted beat with Last=0: counter++ (saturating at MAX_BURST).
    - Idle cycles (valid low) inside a packet keep the lock.
- Ready rule: InxReady_SO = Free & (granted x). It must not depend on the requester's own Valid except through Sel in IDLE. In IDLE with no valid input, both readies = 0.
- Output register update:
  - On an accepted beat: OutData_DO <= selected data (MUX2 function), OutLast_SO <= Last, OutSrc_SO <= Sel, OutValid_SO <= 1.
  - Else if OutReady_SI: OutValid_SO <= 0, and data/Last/Src hold.
  - While OutValid_SO=1 & OutReady_SI=0, all Out* are stable.
- Latency: 1 cycle from input acceptance to OutValid_SO.
- Throughput: 1 beat/cycle with OutReady_SI held high. Input switches at packet boundaries with zero bubble cycles.
- Error flag:
  - ErrLong_SO is set when a beat with Last=0 is accepted while counter == MAX_BURST-1, i.e. the MAX_BURST-th beat is not last.
  - It is sticky until reset.
  - The lock is NOT released and data is unaffected.
- Simultaneous events:
  - A Last acceptance and a new request in the same cycle: the new grant is decided next cycle from IDLE with the updated Prio_S.
  - A downstream pop and a new accept in the same cycle: the register loads the new beat, and OutValid_SO stays 1.
- Reset mid-packet: the partial packet is dropped. State returns to IDLE, OutValid_SO=0 after the reset edge, and no Last is emitted. The upstream is responsible for re-sending.

Test Plan:
1. Reset, then In0 sends a 3-beat packet (0x0001, 0x0002, 0x0003 with Last) while In1 is idle and OutReady=1 -> Out shows 0x0001..0x0003 one cycle after each accept, OutSrc=0, OutLast=1 on 0x0003, then Prio_S=1.
2. Both inputs valid with 1-beat packets (In0=0xAAAA, In1=0x5555) held continuously -> outputs alternate 0xAAAA, 0x5555, 0xAAAA..., starting with In0 after reset, with no bubbles.
3. In0 sends a 4-beat packet while In1 is valid from cycle 1 -> In1Ready=0 for all 4 beats; In1's beat is output immediately after In0's Last with zero idle cycles.
4. Backpressure: OutReady=0 for 5 cycles during a packet -> OutData/OutLast/OutSrc are stable, both InReady=0, and no beat is lost or duplicated after OutReady returns to 1.
5. MAX_BURST=4 with a 6-beat packet -> ErrLong_SO rises the cycle after the 4th accepted beat, all 6 beats pass through, and the flag stays 1 after Last until Rst_RI.
6. Assert Rst_RI for 1 cycle in the middle of beat 2 of a 3-beat packet -> next cycle OutValid=0, state IDLE, Prio_S=0; the following request from In1 is granted normally.
